// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding, divide-by-zero constant and request struct for the iterative divider.
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;
  localparam logic DIV0_Q_BIT = 1'b1;
  localparam int DIV_W = 32;
  typedef struct packed {
    logic             is_signed;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
  } div_req_t;
endpackage

// File: rtl/div_abs.sv
// div_abs: combinational conditional negate, used for magnitudes and result sign fixup.
module div_abs #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);
  assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/iter_div_unit.sv
// iter_div_unit: radix-2 restoring divider, one iteration per cycle, start/done handshake.
// Optional ITER_DIV_EARLY_OUT_EN skips iteration when |divisor| > |dividend|.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div0
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_e r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q, r_rem, r_dsr, r_quot, r_rmd;
  logic [WIDTH-1:0] w_dvd_mag, w_dsr_mag, w_q_fix, w_r_fix;
  logic [WIDTH:0] w_shift, w_diff;
  logic r_sign_q, r_sign_r, r_zero, r_div0, r_done;
  logic w_zero, w_early, w_accept;
  div_abs #(.WIDTH(WIDTH)) u_dvd (.i_neg(i_is_signed & i_dividend[WIDTH-1]), .i_val(i_dividend), .o_val(w_dvd_mag));
  div_abs #(.WIDTH(WIDTH)) u_dsr (.i_neg(i_is_signed & i_divisor[WIDTH-1]), .i_val(i_divisor), .o_val(w_dsr_mag));
  div_abs #(.WIDTH(WIDTH)) u_qfx (.i_neg(r_sign_q), .i_val(r_q), .o_val(w_q_fix));
  div_abs #(.WIDTH(WIDTH)) u_rfx (.i_neg(r_sign_r), .i_val(r_rem), .o_val(w_r_fix));
  assign w_zero   = i_divisor == '0;
  assign w_accept = r_state == IDLE && i_start && !i_flush;
`ifdef ITER_DIV_EARLY_OUT_EN
  assign w_early = !w_zero && (w_dsr_mag > w_dvd_mag);
`else
  assign w_early = 1'b0;
`endif
  // The partial remainder can reach 2*divisor, so the trial subtract needs one extra bit.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  always_comb begin
    w_next = r_state;
    if (i_flush) w_next = IDLE;
    else if (r_state == IDLE) w_next = i_start ? ((w_zero || w_early) ? FIX : CALC) : IDLE;
    else if (r_state == CALC) w_next = (r_cnt == CNT_W'(1)) ? FIX : CALC;
    else w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_dsr    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_zero   <= 1'b0;
      r_quot   <= '0;
      r_rmd    <= '0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == FIX && !i_flush;
      if (w_accept) begin
        // Divide-by-zero parks the raw dividend and all-ones quotient so FIX passes them through.
        r_sign_q <= !w_zero & i_is_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
        r_sign_r <= !w_zero & i_is_signed & i_dividend[WIDTH-1];
        r_dsr    <= w_dsr_mag;
        r_cnt    <= CNT_W'(WIDTH);
        r_zero   <= w_zero;
        r_q      <= w_zero ? {WIDTH{DIV0_Q_BIT}} : (w_early ? '0 : w_dvd_mag);
        r_rem    <= w_zero ? i_dividend : (w_early ? w_dvd_mag : '0);
      end else if (r_state == CALC && !i_flush) begin
        r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (r_state == FIX && !i_flush) begin
        r_quot <= w_q_fix;
        r_rmd  <= w_r_fix;
        r_div0 <= r_zero;
      end
    end
  end
  assign o_ready     = r_state == IDLE;
  assign o_busy      = !o_ready;
  assign o_done      = r_done;
  assign o_quotient  = r_quot;
  assign o_remainder = r_rmd;
  assign o_div0      = r_div0;
endmodule

// File: tb/tb_iter_div_unit.sv
// tb_iter_div_unit: randomized and directed checks of iter_div_unit against an arithmetic model.
module tb_iter_div_unit;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, start = 1'b0, is_signed = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic ready, busy, done, div0;
  logic [W-1:0] quotient, remainder;
  int n_chk = 0, n_fail = 0;
  longint cyc = 0;
  typedef struct {logic [W-1:0] q; logic [W-1:0] r; logic z; longint due;} exp_t;
  exp_t sb[$];
  exp_t ce;

  iter_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_start(start), .i_is_signed(is_signed),
    .i_dividend(dividend), .i_divisor(divisor), .o_ready(ready), .o_busy(busy), .o_done(done),
    .o_quotient(quotient), .o_remainder(remainder), .o_div0(div0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb_;
    if (b == '0) begin q = '1; r = a; z = 1'b1; end
    else if (s) begin
      sa = longint'($signed(a)); sb_ = longint'($signed(b));
      q = W'(sa / sb_); r = W'(sa % sb_); z = 1'b0;
    end else begin q = a / b; r = a % b; z = 1'b0; end
  endfunction

  function automatic int lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ITER_DIV_EARLY_OUT_EN
    longint ma, mb;
    ma = s ? longint'($signed(a)) : longint'(a);
    mb = s ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b != '0 && mb > ma) return 1;
`endif
    if (b == '0) return 1;
    return W + 1;
  endfunction

  always @(negedge clk) if (rst_n) begin
    chk("ready_not_busy", {63'd0, ready}, {63'd0, !busy});
    if (done) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        ce = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(ce.q));
        chk("remainder", 64'(remainder), 64'(ce.r));
        chk("div0", 64'(div0), 64'(ce.z));
        chk("done_cycle", 64'(cyc), 64'(ce.due));
        chk("ready_in_done", 64'(ready), 64'd1);
      end
    end else if (sb.size() > 0) chk("busy_in_flight", 64'(busy), 64'd1);
  end

  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
    longint n0;
    exp_t e;
    @(negedge clk);
    while (!ready && k < 200) begin @(negedge clk); k++; end
    if (!ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1");
    end
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    n0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    model(s, a, b, e.q, e.r, e.z);
    e.due = n0 + lat(s, a, b) + 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 200) begin @(negedge clk); k++; end
    if (sb.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return W'($urandom_range(0, 20));
      3: return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] mq, mr;
    logic mz, s;
    logic [W-1:0] a, b;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    chk("rst_div0", 64'(div0), 64'd0);
    model(1'b0, 32'd100, 32'd7, mq, mr, mz);
    chk("model_100_7", {mq, mr}, {32'd14, 32'd2});
    model(1'b1, -32'd7, 32'd2, mq, mr, mz);
    chk("model_m7_2", {mq, mr}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mq, mr, mz);
    chk("model_min_m1", {mq, mr}, {32'h8000_0000, 32'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 32'd100, 32'd7);
    drain();
    chk("dut_100_7", {quotient, remainder}, {32'd14, 32'd2});
    do_op(1'b1, -32'd7, 32'd2);
    do_op(1'b1, 32'd7, -32'd2);
    drain();
    chk("dut_7_m2", {quotient, remainder}, {32'hFFFF_FFFD, 32'd1});
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();
    chk("dut_min_m1", {quotient, remainder, 31'd0, div0}, {32'h8000_0000, 32'd0, 32'd0});
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b1, 32'h1234, 32'd0);
    drain();
    chk("dut_div0", {quotient, remainder, 31'd0, div0}, {32'hFFFF_FFFF, 32'h1234, 32'd1});
    do_op(1'b0, 32'd3, 32'd9);
    drain();
    chk("dut_3_9", {quotient, remainder}, {32'd0, 32'd3});
    do_op(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_ready", 64'(ready), 64'd1);
    do_op(1'b0, 32'd50, 32'd5);
    drain();
    chk("dut_50_5", {quotient, remainder}, {32'd10, 32'd0});
    @(negedge clk);
    start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("start_flush_ready", 64'(ready), 64'd1);
    chk("start_flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("start_flush_hold", {quotient, remainder}, {32'd10, 32'd0});
    do_op(1'b1, 32'd12345, 32'd17);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_q", 64'(quotient), 64'd0);
    chk("arst_r", 64'(remainder), 64'd0);
    chk("arst_ready", 64'(ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = ($urandom_range(0, 15) == 0) ? '0 : pick();
      do_op(s, a, b);
    end
    drain();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Parametrised, multi-cycle, radix-2 restoring divider for the EX stage.
- Supports signed and unsigned operation on WIDTH-bit operands.
- Uses a start/done handshake, a flush input and divide-by-zero detection.
- Replaces the fixed 32-stage pipelined divider: one shared datapath, one iteration per cycle, an explicit FSM and registered results held until the next start.

Parameters:
- WIDTH, 32: operand, quotient and remainder width; must be at least 4.
- CNT_W, $clog2(WIDTH+1): derived localparam for the iteration counter width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  exception flush; aborts any operation in flight.
- start  in  1  request; accepted only when ready=1.
- is_signed  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- ready  out  1  unit idle; next start will be accepted.
- busy  out  1  operation in flight; the pipeline stalls on this.
- done  out  1  one-cycle pulse; quotient, remainder and div0 are valid from this cycle.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div0  out  1  registered divide-by-zero flag for the last completed operation.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ready=1, busy=0, done=0.
  - quotient=0, remainder=0, div0=0, iteration counter=0.
- States:
  - IDLE: ready=1, busy=0.
  - CALC: ready=0, busy=1.
  - FIX: ready=0, busy=1.
- IDLE, on start=1 && flush=0 at edge N:
  - Latch sign_q = is_signed & (dividend[MSB] ^ divisor[MSB]).
  - Latch sign_r = is_signed & dividend[MSB].
  - Latch the magnitudes |dividend| and |divisor|; the magnitude of MIN is taken as the unsigned 2^(WIDTH-1).
  - Clear the partial remainder; counter=WIDTH; go to CALC.
- IDLE, divisor==0 at start: skip CALC and go directly to FIX with the zero flag latched.
- start while not ready: ignored. The producer must hold its request until ready=1.
- CALC, one iteration per edge:
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor magnitude; a non-negative result is kept and the quotient bit is 1.
  - Decrement the counter. The edge on which the counter reaches 0 moves the state to FIX.
- FIX, one edge:
  - quotient = sign_q ? -q_mag : q_mag.
  - remainder = sign_r ? -r_mag : r_mag.
  - Set div0; done=1 for exactly the following cycle; return to IDLE.
- Latency:
  - Normal operation: done is high in the cycle after edge N+WIDTH+1.
  - Divide-by-zero: done is high in the cycle after edge N+1.
- ready in the done cycle: ready=1 in the same cycle as done, so back-to-back starts are legal.
- Divide-by-zero result: quotient = all ones, remainder = dividend unmodified, div0=1. Applies to both signed and unsigned.
- Signed MIN / -1: quotient=MIN, remainder=0, div0=0. This falls out of the algorithm and needs no special case.
- Remainder sign: always follows the dividend; |remainder| < |divisor|.
- Result hold: quotient, remainder and div0 keep their values after done until the next FIX edge.
- flush=1:
  - From any state, goes to IDLE at the next edge; no done is generated.
  - Output registers keep their previous values.
  - If flush and start occur in the same cycle, flush wins and the start is dropped.
- Reset mid-operation: immediate return to the reset values; no done.

Optional Feature:
- Macro: ITER_DIV_EARLY_OUT_EN.
- Defined: at start, if divisor!=0 and |divisor| > |dividend|, skip CALC and go to FIX with q_mag=0 and r_mag=|dividend|. done arrives at N+1, the same as divide-by-zero.
- Undefined: every non-zero divisor takes the full WIDTH+1 latency.
- Results are identical in both builds; only the latency differs.

Decomposition:
- Shared package div_pkg holds:
  - The FSM state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - The DIV0 quotient constant (all ones).
  - A div_req struct {is_signed, dividend, divisor} for use by the ALU wrapper.
- One sub-module, div_abs, is natural: a combinational conditional-negate block, instantiated for operand magnitude extraction and for result sign fixup.
- The FSM, counter and restoring step stay in iter_div_unit.

Test Plan (WIDTH=32):
- Unsigned 100/7, is_signed=0 -> quotient=14, remainder=2, div0=0. done exactly 33 cycles after the start edge; ready low in between.
- Signed -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7/-2 -> quotient=-3, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div0=0. Unsigned same operands -> quotient=0, remainder=0x80000000.
- Divisor=0, dividend=0x1234 -> quotient=0xFFFFFFFF, remainder=0x1234, div0=1, done 1 cycle after start.
- Flush at cycle 10 of CALC, then start 50/5 -> no done for the aborted operation; the second operation yields quotient=10, remainder=0. Also assert start+flush in the same cycle -> start dropped, ready stays 1.
- Reset asserted mid-CALC -> all outputs zero asynchronously, before the next edge. With ITER_DIV_EARLY_OUT_EN, 3/9 -> quotient=0, remainder=3, done after 1 cycle; without it, the same result after 33 cycles.
